// File: rtl/array_sp_init_ext.sv
// array_sp_init_ext: single-port RW SRAM model with segment write mask,
// 1/2-cycle registered read and a constant-fill initialisation engine.
`default_nettype none

module array_sp_init_ext #(
  parameter int              DEPTH        = 256,
  parameter int              WIDTH        = 16,
  parameter int              MASK_GRAN    = 8,
  parameter int              READ_LATENCY = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
  localparam int             ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             MASK_SEG     = WIDTH / MASK_GRAN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   RW0_addr,
  input  logic                RW0_en,
  input  logic                RW0_wmode,
  input  logic [WIDTH-1:0]    RW0_wdata,
  input  logic [MASK_SEG-1:0] RW0_wmask,
  output logic [WIDTH-1:0]    RW0_rdata,
  output logic                RW0_rvalid,
  input  logic                init_req,
  output logic                init_done
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              in_range;
  logic              rd_fire;
  logic              wr_fire;
  logic [WIDTH-1:0]  rd_word;

  // Non-power-of-two depths leave a hole at the top of the address space.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (32'(RW0_addr) < DEPTH);
  end

  assign rd_fire   = (state == ST_READY) && RW0_en && !RW0_wmode;
  assign wr_fire   = (state == ST_READY) && RW0_en &&  RW0_wmode && in_range;
  assign rd_word   = in_range ? mem[RW0_addr] : '0;
  assign init_done = (state == ST_READY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_INIT: begin
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Storage has no reset; the init engine owns the write port while in INIT.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      mem[cnt] <= INIT_VALUE;
    end else if (wr_fire) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (RW0_wmask[i]) begin
          mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_valid   <= 1'b0;
        s1_data    <= '0;
        RW0_rdata  <= '0;
        RW0_rvalid <= 1'b0;
      end else begin
        s1_valid   <= rd_fire;
        if (rd_fire) begin
          s1_data  <= rd_word;
        end
        RW0_rvalid <= s1_valid;
        if (s1_valid) begin
          RW0_rdata <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        RW0_rdata  <= '0;
        RW0_rvalid <= 1'b0;
      end else begin
        RW0_rvalid <= rd_fire;
        if (rd_fire) begin
          RW0_rdata <= rd_word;
        end
      end
    end
  end

endmodule

`default_nettype wire
